// File: rtl/dma_desc_queue.sv
// DMA descriptor queue: a 4-deep FIFO of {cmd, desc} words drained by a small
// handshake engine (REQ -> GRANT -> RUN -> DONE) toward an external DMA.
// Malformed entries are discarded at dequeue, RUN is guarded by a watchdog,
// and sticky error flags record overflow, bad descriptors and timeouts.
module dma_desc_queue #(
  parameter int TMO_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_desc,
  input  logic [1:0]  push_cmd,
  output logic        full,
  output logic        empty,
  output logic [2:0]  level,
  output logic        dreq,
  input  logic        hreq,
  output logic        hack,
  input  logic        dack,
  input  logic        intr,
  output logic [31:0] desc,
  output logic        desc_oe,
  output logic [1:0]  cmd,
  output logic        busy,
  output logic        done,
  output logic [7:0]  done_count,
  output logic        err_ovf,
  output logic        err_bad,
  output logic        err_tmo,
  input  logic        clr_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_GRANT = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [8:0] TMO_LIMIT = 9'(TMO_CYCLES);

  state_t      state;
  state_t      state_nxt;

  logic [33:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;

  logic [33:0] head;
  logic [1:0]  head_cmd;
  logic [31:0] head_desc;
  logic        head_valid;

  logic        pop;
  logic        push_ok;
  logic        ovf_set;
  logic        bad_set;
  logic        tmo_set;
  logic        load_desc;
  logic        start_run;
  logic        leave_run;
  logic        wdog_expired;

  logic [7:0]  wdog;
  logic        run_ok;
  logic [1:0]  cmd_q;
  logic [31:0] desc_q;

  assign head       = mem[rd_ptr];
  assign head_cmd   = head[33:32];
  assign head_desc  = head[31:0];
  assign head_valid = (head_desc[31:26] != 6'd0) &&
                      ((head_cmd == 2'b00) || (head_cmd == 2'b10));

  assign full  = (count == 3'd4);
  assign empty = (count == 3'd0);
  assign level = count;

  // A push into a full queue still fits when the head leaves on the same edge.
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  // The watchdog value is the number of RUN cycles already completed.
  assign wdog_expired = (state == S_RUN) && (({1'b0, wdog} + 9'd1) >= TMO_LIMIT);

  // Next-state decode plus the one-cycle control strobes that go with each move.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    bad_set   = 1'b0;
    tmo_set   = 1'b0;
    load_desc = 1'b0;
    start_run = 1'b0;
    leave_run = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          if (head_valid) begin
            state_nxt = S_REQ;
            load_desc = 1'b1;
          end else begin
            pop     = 1'b1;
            bad_set = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (hreq) begin
          state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (dack) begin
          state_nxt = S_RUN;
          start_run = 1'b1;
        end
      end
      S_RUN: begin
        if (intr) begin
          state_nxt = S_DONE;
          leave_run = 1'b1;
        end else if (wdog_expired) begin
          state_nxt = S_DONE;
          leave_run = 1'b1;
          tmo_set   = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        pop       = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Handshake outputs are pure decodes of the state so reset drops them at once.
  always_comb begin
    dreq    = (state == S_REQ) || (state == S_GRANT) || (state == S_RUN);
    hack    = (state == S_GRANT) || (state == S_RUN);
    desc_oe = (state == S_REQ) || (state == S_GRANT);
    busy    = (state != S_IDLE);
    done    = (state == S_DONE) && run_ok;
    cmd     = cmd_q;
    desc    = desc_q;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FIFO storage, pointers and occupancy; both pointers wrap naturally at 2 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        mem[i] <= 34'd0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {push_cmd, push_desc};
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Descriptor and command registers facing the DMA; cmd is only live during RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      desc_q <= 32'd0;
      cmd_q  <= 2'b00;
    end else begin
      if (load_desc) begin
        desc_q <= head_desc;
      end
      if (start_run) begin
        cmd_q <= head_cmd;
      end else if (leave_run) begin
        cmd_q <= 2'b00;
      end
    end
  end

  // Watchdog and outcome of the transfer; an int on the expiry edge counts as success.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog   <= 8'd0;
      run_ok <= 1'b0;
    end else begin
      if (start_run) begin
        wdog <= 8'd0;
      end else if (state == S_RUN) begin
        wdog <= wdog + 8'd1;
      end
      if (leave_run) begin
        run_ok <= intr;
      end
    end
  end

  // Completed-descriptor counter, bumped as DONE retires a successful entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_count <= 8'd0;
    end else if ((state == S_DONE) && run_ok) begin
      done_count <= done_count + 8'd1;
    end
  end

  // Sticky error flags; a fresh error wins over a clear on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_ovf <= 1'b0;
      err_bad <= 1'b0;
      err_tmo <= 1'b0;
    end else begin
      err_ovf <= ovf_set || (err_ovf && !clr_err);
      err_bad <= bad_set || (err_bad && !clr_err);
      err_tmo <= tmo_set || (err_tmo && !clr_err);
    end
  end

endmodule

// File: tb/tb_dma_desc_queue.sv
// Testbench for dma_desc_queue: directed scenarios for the key corner cases
// followed by a randomized phase, with a scoreboard queue of accepted entries
// checked by an independent monitor process.
module tb_dma_desc_queue;

  localparam int TMO = 255;

  logic        clk;
  logic        reset;
  logic        push;
  logic [31:0] push_desc;
  logic [1:0]  push_cmd;
  logic        full;
  logic        empty;
  logic [2:0]  level;
  logic        dreq;
  logic        hreq;
  logic        hack;
  logic        dack;
  logic        intr;
  logic [31:0] desc;
  logic        desc_oe;
  logic [1:0]  cmd;
  logic        busy;
  logic        done;
  logic [7:0]  done_count;
  logic        err_ovf;
  logic        err_bad;
  logic        err_tmo;
  logic        clr_err;

  dma_desc_queue #(.TMO_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_desc  (push_desc),
    .push_cmd   (push_cmd),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .dreq       (dreq),
    .hreq       (hreq),
    .hack       (hack),
    .dack       (dack),
    .intr       (intr),
    .desc       (desc),
    .desc_oe    (desc_oe),
    .cmd        (cmd),
    .busy       (busy),
    .done       (done),
    .done_count (done_count),
    .err_ovf    (err_ovf),
    .err_bad    (err_bad),
    .err_tmo    (err_tmo),
    .clr_err    (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [31:0] desc;
  } entry_t;

  // Scoreboard: every entry the queue is expected to hold, oldest first.
  entry_t     mq[$];
  int         checks = 0;
  int         passes = 0;
  logic [7:0] exp_done_count = 8'd0;
  int         done_pulses = 0;

  // Knobs for the behavioural DMA responder.
  bit dma_stall  = 1'b0;
  bit dma_no_int = 1'b0;
  bit dma_noise  = 1'b0;
  int h_delay    = 1;
  int d_delay    = 0;
  int i_delay    = 2;

  function automatic bit entry_ok(entry_t e);
    return (e.desc[31:26] != 6'd0) && ((e.cmd == 2'b00) || (e.cmd == 2'b10));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic failNow(input string name);
    checks++;
    $display("[TB] FAIL %s: got an unexpected or missing event, expected none", name);
  endtask

  task automatic applyStimulus(input logic [1:0] c, input logic [31:0] d, input bit expect_accept);
    entry_t e;
    e.cmd     = c;
    e.desc    = d;
    push      = 1'b1;
    push_cmd  = c;
    push_desc = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    if (expect_accept) mq.push_back(e);
  endtask

  task automatic clearErrors();
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
  endtask

  task automatic waitIdle(input int limit, input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!((busy == 1'b0) && (empty == 1'b1)) && (n < limit));
    if (n >= limit) failNow({name, "_drain_timeout"});
  endtask

  task automatic waitRun(input int limit, input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(hack && !desc_oe) && (n < limit));
    if (n >= limit) failNow({name, "_run_timeout"});
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_level"}, level, 0);
    checkOutput({tag, "_empty"}, empty, 1);
    checkOutput({tag, "_full"}, full, 0);
    checkOutput({tag, "_dreq"}, dreq, 0);
    checkOutput({tag, "_hack"}, hack, 0);
    checkOutput({tag, "_desc_oe"}, desc_oe, 0);
    checkOutput({tag, "_desc"}, desc, 0);
    checkOutput({tag, "_cmd"}, cmd, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_done_count"}, done_count, 0);
    checkOutput({tag, "_errs"}, {err_ovf, err_bad, err_tmo}, 0);
  endtask

  // DMA responder: answers each waiting phase after a programmable delay and,
  // when noise is on, toggles the other handshake inputs at random.
  initial begin : dma_model
    int phase;
    int last_phase;
    int wait_cnt;
    last_phase = 0;
    wait_cnt   = 0;
    hreq = 1'b0;
    dack = 1'b0;
    intr = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (desc_oe && !hack)      phase = 1;
      else if (desc_oe && hack)  phase = 2;
      else if (hack)             phase = 3;
      else                       phase = 0;
      if (phase != last_phase) wait_cnt = 0;
      else                     wait_cnt++;
      last_phase = phase;
      if (reset || dma_stall) begin
        hreq = 1'b0;
        dack = 1'b0;
        intr = 1'b0;
      end else begin
        hreq = (phase == 1) ? (wait_cnt >= h_delay) : (dma_noise && ($urandom_range(0, 3) == 0));
        dack = (phase == 2) ? (wait_cnt >= d_delay) : (dma_noise && ($urandom_range(0, 3) == 0));
        intr = (phase == 3) ? (!dma_no_int && (wait_cnt >= i_delay))
                            : (dma_noise && ($urandom_range(0, 3) == 0));
      end
    end
  end

  // Done-pulse counter used by the single-transfer scenario.
  always @(negedge clk) begin
    if (!reset && done) done_pulses++;
  end

  // Monitor: compares what the DUT presents against the scoreboard queue.
  initial begin : monitor
    bit prev_oe;
    bit prev_run;
    bit run_now;
    bit count_due;
    bit last_run_int;
    prev_oe      = 1'b0;
    prev_run     = 1'b0;
    count_due    = 1'b0;
    last_run_int = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_oe      = 1'b0;
        prev_run     = 1'b0;
        count_due    = 1'b0;
        last_run_int = 1'b0;
        continue;
      end
      if (count_due) begin
        checkOutput("done_count", done_count, exp_done_count);
        count_due = 1'b0;
      end
      // An idle queue throws away one malformed head per cycle.
      if (!busy && (mq.size() > 0) && !entry_ok(mq[0])) void'(mq.pop_front());
      if (desc_oe && !prev_oe) begin
        if (mq.size() == 0) failNow("desc_present");
        else checkOutput("desc", desc, mq[0].desc);
      end
      run_now = hack && !desc_oe;
      if (run_now && !prev_run) begin
        if (mq.size() == 0) failNow("run_cmd");
        else checkOutput("run_cmd", cmd, mq[0].cmd);
      end
      if (run_now) last_run_int = intr;
      if (busy && !dreq) begin
        checkOutput("done_pulse", done, last_run_int);
        checkOutput("done_cmd_hack", {cmd, hack, desc_oe}, 0);
        if (mq.size() == 0) failNow("done_retire");
        else void'(mq.pop_front());
        if (last_run_int) exp_done_count++;
        count_due = 1'b1;
      end else if (done) begin
        failNow("done_outside_done");
      end
      prev_oe  = desc_oe;
      prev_run = run_now;
    end
  end

  // Global time bound so the bench can never hang.
  initial begin : time_guard
    #2000000;
    $display("[TB] FAIL global_timeout: got no completion, expected finish");
    $fatal(1, "[TB] simulation time bound exceeded");
  end

  // Main stimulus: directed scenarios then randomized traffic.
  initial begin : main
    int         pulses_before;
    int         run_cycles;
    int         rand_valid;
    bit         rand_bad;
    logic [7:0] count_before;
    logic [5:0] cnt;
    logic [1:0] c;
    logic [31:0] d;
    int         r;

    reset     = 1'b0;
    push      = 1'b0;
    push_desc = 32'd0;
    push_cmd  = 2'b00;
    clr_err   = 1'b0;
    #1 reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single descriptor with a well-behaved DMA.
    pulses_before = done_pulses;
    applyStimulus(2'b00, 32'h0400_8000, 1'b1);
    waitIdle(60, "t030");
    checkOutput("t030_done_count", done_count, 1);
    checkOutput("t030_empty", empty, 1);
    checkOutput("t030_pulses", done_pulses - pulses_before, 1);

    // Overflow while the DMA stalls; the last push also meets a clear.
    dma_stall = 1'b1;
    clearErrors();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) clr_err = 1'b1;
      applyStimulus(2'b10, 32'h0800_0000 | (i << 4), i < 4);
      clr_err = 1'b0;
    end
    checkOutput("t031_level", level, 4);
    checkOutput("t031_full", full, 1);
    checkOutput("t031_err_ovf", err_ovf, 1);
    dma_stall = 1'b0;
    waitIdle(300, "t031");
    checkOutput("t031_done_count", done_count, 5);

    // Push into a full queue on the same edge that DONE retires the head.
    dma_stall = 1'b1;
    clearErrors();
    for (int i = 0; i < 4; i++) applyStimulus(2'b00, 32'h1000_0100 + i, 1'b1);
    dma_stall = 1'b0;
    begin
      int n;
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!(busy && !dreq) && (n < 100));
      if (n >= 100) failNow("t035_done_timeout");
    end
    applyStimulus(2'b10, 32'h1400_0ABC, 1'b1);
    checkOutput("t035_level", level, 4);
    checkOutput("t035_err_ovf", err_ovf, 0);
    waitIdle(400, "t035");
    checkOutput("t035_done_count", done_count, 10);

    // Malformed descriptor followed by a good one.
    clearErrors();
    applyStimulus(2'b00, 32'h0000_1234, 1'b1);
    applyStimulus(2'b10, 32'h0C00_2345, 1'b1);
    waitIdle(100, "t032");
    checkOutput("t032_err_bad", err_bad, 1);
    checkOutput("t032_done_count", done_count, 11);

    // Watchdog expiry, then the queue moves on to the next entry.
    clearErrors();
    dma_no_int = 1'b1;
    applyStimulus(2'b00, 32'h0800_0001, 1'b1);
    applyStimulus(2'b10, 32'h0800_0002, 1'b1);
    waitRun(50, "t033");
    run_cycles = 1;
    while ((hack && !desc_oe) && (run_cycles < 400)) begin
      @(posedge clk);
      #1;
      if (hack && !desc_oe) run_cycles++;
      else break;
    end
    checkOutput("t033_run_cycles", run_cycles, TMO);
    checkOutput("t033_err_tmo", err_tmo, 1);
    checkOutput("t033_no_done", done, 0);
    dma_no_int = 1'b0;
    waitIdle(100, "t033");
    checkOutput("t033_done_count", done_count, 12);
    clearErrors();
    checkOutput("t033_err_clear", {err_ovf, err_bad, err_tmo}, 0);

    // Reset in the middle of RUN with two entries still queued.
    dma_no_int = 1'b1;
    applyStimulus(2'b00, 32'h0800_0011, 1'b1);
    applyStimulus(2'b00, 32'h0800_0022, 1'b1);
    applyStimulus(2'b10, 32'h0800_0033, 1'b1);
    waitRun(50, "t034");
    checkOutput("t034_level_before", level, 3);
    reset = 1'b1;
    #1;
    checkResetState("t034");
    mq.delete();
    exp_done_count = 8'd0;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    dma_no_int = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic with handshake noise; pushes only when space is certain.
    dma_noise  = 1'b1;
    rand_valid = 0;
    rand_bad   = 1'b0;
    count_before = done_count;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if ($urandom_range(0, 15) == 0) begin
        h_delay = $urandom_range(0, 3);
        d_delay = $urandom_range(0, 3);
        i_delay = $urandom_range(0, 6);
      end
      if (($urandom_range(0, 2) == 0) && (mq.size() < 4)) begin
        cnt = ($urandom_range(0, 6) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        r   = $urandom_range(0, 9);
        c   = (r == 0) ? 2'b01 : (r == 1) ? 2'b11 : (r < 6) ? 2'b00 : 2'b10;
        d   = {cnt, 13'($urandom), 13'($urandom)};
        if ((cnt != 6'd0) && ((c == 2'b00) || (c == 2'b10))) rand_valid++;
        else rand_bad = 1'b1;
        applyStimulus(c, d, 1'b1);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    waitIdle(2000, "rand");
    dma_noise = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rand_done_count", done_count, 8'(count_before + rand_valid));
    checkOutput("rand_err_bad", err_bad, rand_bad);
    checkOutput("rand_err_ovf_tmo", {err_ovf, err_tmo}, 0);
    checkOutput("rand_model_drained", mq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dma_desc_queue.md
DMA_DESC_QUEUE -- requirements
Module: dma_desc_queue

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have ports: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have ports: push  input  1  enqueue request from processor, sampled on clk.
REQ-004 SHALL have ports: push_desc  input  32  DMA instruction word: [31:26] count, [25:13] source, [12:0] destination.
REQ-005 SHALL have ports: push_cmd  input  2  DMA command for this descriptor: 00 read, 10 move; 01/11 reserved.
REQ-006 SHALL have ports: full, empty  output  1 each  queue status; level  output  3  entries held (0..4).
REQ-007 SHALL have ports: dreq  output  1  request to DMA; hreq  input  1  DMA wants bus; hack  output  1  bus granted.
REQ-008 SHALL have ports: dack  input  1  DMA has taken bus; int  input  1  DMA transfer finished.
REQ-009 SHALL have ports: desc  output  32  descriptor presented to DMA; desc_oe  output  1  desc valid; cmd  output  2  active command.
REQ-010 SHALL have ports: busy  output  1; done  output  1  one-cycle pulse per completed descriptor; done_count  output  8.
REQ-011 SHALL have ports: err_ovf, err_bad, err_tmo  output  1 each  sticky error flags; clr_err  input  1  clears them.
REQ-012 Parameter TMO_CYCLES, default 255, meaning max cycles in RUN awaiting int.

Function
REQ-013 Storage SHALL be a 4-entry FIFO of 34-bit entries {cmd, desc}; 2-bit read/write pointers wrap 3->0.
REQ-014 push with full=0 SHALL write entry at write pointer and increment level at the same edge.
REQ-015 push with full=1 SHALL be dropped, entries unchanged, err_ovf set, except when a pop occurs on the same edge, in which case the push SHALL be accepted and level stays 4.
REQ-016 Entries with count==0 or cmd 01/11 SHALL be dropped at dequeue (IDLE->pop, no dreq), err_bad set, done not pulsed.
REQ-017 FSM states SHALL be IDLE, REQ, GRANT, RUN, DONE; busy=1 in every state except IDLE.
REQ-018 IDLE: if empty=0 and head entry valid, go REQ next edge; desc/cmd loaded from head.
REQ-019 REQ: dreq=1, desc_oe=1; on hreq=1 go GRANT.
REQ-020 GRANT: dreq=1, hack=1, desc_oe=1; on dack=1 go RUN and drive cmd from entry.
REQ-021 RUN: dreq=1, hack=1, desc_oe=0, cmd held; 8-bit watchdog counts cycles from RUN entry.
REQ-022 RUN with int=1 SHALL go DONE; int and watchdog expiry on same edge SHALL be treated as int (success).
REQ-023 Watchdog reaching TMO_CYCLES without int SHALL set err_tmo and go DONE without done pulse.
REQ-024 DONE (exactly one cycle): dreq=0, hack=0, cmd=00, desc_oe=0; pop head; done=1 and done_count+1 (wraps 255->0) on success only; next state IDLE.
REQ-025 Back-to-back descriptors SHALL have minimum gap of one IDLE cycle between DONE and next REQ.
REQ-026 hreq/dack/int outside their waiting state SHALL be ignored.
REQ-027 clr_err=1 SHALL clear all three error flags; a new error on the same edge SHALL take priority (flag stays 1).

Reset
REQ-028 reset=1 SHALL immediately force: state IDLE, pointers 0, level 0, empty=1, full=0, dreq=0, hack=0, desc_oe=0, desc=0, cmd=00, busy=0, done=0, done_count=0, all error flags 0.
REQ-029 reset asserted mid-transfer SHALL abort without pulsing done; queued entries are discarded.

Verification
REQ-030 Push {cmd=00, desc=0x04008000}; DMA answers hreq 1 cycle after dreq, dack next, int 3 cycles later -> hack/dreq drop in DONE, done pulses once, done_count=1, empty=1.
REQ-031 Push 5 descriptors in 5 consecutive cycles while idle-stalled (hreq held 0) -> level=4, full=1, err_ovf=1, fifth lost.
REQ-032 Push desc with count=0, then valid desc -> first dropped, err_bad=1, second executes normally, done_count=1.
REQ-033 Hold int=0 in RUN -> after 255 cycles err_tmo=1, DONE with no done pulse, queue advances to next entry.
REQ-034 Assert reset while in RUN with 2 entries queued -> all outputs at REQ-028 values same cycle, level=0.
REQ-035 Queue full with DONE in progress and push on same edge -> push accepted, level stays 4, err_ovf=0.
